// File: rtl/boron_pkg.sv
// Shared BORON-64/80 constants: widths, round count, key rotation, S-box table and FSM states.
package boron_pkg;

    localparam int unsigned KEY_W  = 80;
    localparam int unsigned RK_W   = 64;
    localparam int unsigned ROUNDS = 25;
    localparam int unsigned ROT    = 13;
    localparam int unsigned IDX_W  = 5;

    // Entry x occupies bits [4x+3:4x]: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6 for x=0..F.
    localparam logic [63:0] SBOX = 64'h6358_F02D_AC97_1B4E;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } ks_state_e;

endpackage

// File: rtl/boron_sbox.sv
// 4-bit BORON S-box, shared with the encryption core's S-layer.
module boron_sbox
    import boron_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);

    assign y = SBOX[{x, 2'b00} +: 4];

endmodule

// File: rtl/boron_key_schedule.sv
// BORON-64/80 round-key generator: loads an 80-bit master key and issues RK0..RK25,
// advancing one key per rk_next handshake.
module boron_key_schedule
    import boron_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  master_key,
    input  logic              ks_start,
    input  logic              rk_next,
    output logic [RK_W-1:0]   round_key,
    output logic              rk_valid,
    output logic [IDX_W-1:0]  round_idx,
    output logic              ks_done
);

    ks_state_e        state_q, state_d;
    logic [KEY_W-1:0] kreg_q, kreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [KEY_W-1:0] rotated;
    logic [KEY_W-1:0] updated;
    logic [IDX_W-1:0] rc;
    logic [3:0]       sbox_y;

    assign rotated = {kreg_q[KEY_W-ROT-1:0], kreg_q[KEY_W-1:KEY_W-ROT]};

    boron_sbox u_sbox (
        .x (rotated[3:0]),
        .y (sbox_y)
    );

    always_comb begin
        rc      = idx_q + IDX_W'(1);
        updated = rotated;
        updated[3:0] = sbox_y;
        updated[RK_W-1:RK_W-IDX_W] = rotated[RK_W-1:RK_W-IDX_W] ^ rc;
    end

    always_comb begin
        state_d = state_q;
        kreg_d  = kreg_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (ks_start) begin
                    kreg_d  = master_key;
                    idx_d   = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (rk_next) begin
                    if (idx_q == IDX_W'(ROUNDS)) begin
                        // Final key consumed: leave kreg as is, output is masked outside ACTIVE.
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        kreg_d = updated;
                        idx_d  = rc;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            kreg_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            kreg_q  <= kreg_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        rk_valid  = (state_q == StActive);
        ks_done   = (state_q == StDone);
        round_key = rk_valid ? kreg_q[RK_W-1:0] : '0;
        round_idx = idx_q;
    end

endmodule
